// File: rtl/wb_pkg.sv
// Shared arbitration state encoding, bus constants and the round-robin pick
// used by the two-master Wishbone arbiter.
package wb_pkg;

  localparam int WB_SEL_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  // last_owner=1 means m1 owned most recently, so m0 wins a tie.
  function automatic state_t arbitrate(input logic req0, input logic req1,
                                       input logic last_owner);
    state_t pick;
    pick = ST_IDLE;
    if (req0 && req1) begin
      pick = last_owner ? ST_OWN0 : ST_OWN1;
    end else if (req0) begin
      pick = ST_OWN0;
    end else if (req1) begin
      pick = ST_OWN1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Stall watchdog: counts strobe cycles with no slave termination and pulses
// expire on the last allowed cycle so the owner sees a forced err.
module wb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic stb,
  input  logic term,
  output logic expire
);

  localparam logic [TO_WIDTH-1:0] LIMIT = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TO_WIDTH-1:0] cnt_reg;
  logic [TO_WIDTH-1:0] cnt_next;

  always_comb begin
    expire   = stb && !term && (cnt_reg == LIMIT);
    cnt_next = cnt_reg;
    if (!stb || term || expire) begin
      cnt_next = '0;
    end else if (cnt_reg != {TO_WIDTH{1'b1}}) begin
      // Saturate rather than wrap if the limit were ever unreachable.
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/wb_arbiter_2m_1s.sv
// Two-master, one-slave Wishbone classic arbiter with round-robin grant held
// for the whole bus cycle and an optional stalled-access watchdog.
module wb_arbiter_2m_1s
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic [DATA_WIDTH-1:0]   m0_data_i,
  output logic [DATA_WIDTH-1:0]   m0_data_o,
  input  logic                    m0_cyc_i,
  input  logic [WB_SEL_WIDTH-1:0] m0_sel_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  output logic                    m0_rty_o,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic [DATA_WIDTH-1:0]   m1_data_i,
  output logic [DATA_WIDTH-1:0]   m1_data_o,
  input  logic                    m1_cyc_i,
  input  logic [WB_SEL_WIDTH-1:0] m1_sel_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic                    m1_rty_o,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic [DATA_WIDTH-1:0]   s_data_o,
  input  logic [DATA_WIDTH-1:0]   s_data_i,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [WB_SEL_WIDTH-1:0] s_sel_o,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  input  logic                    s_rty_i,
  output logic [1:0]              gnt_o
);

  state_t state_reg, state_next;
  logic   last_owner_reg, last_owner_next;
  logic   own0, own1;
  logic   term;
  logic   expire;

  assign own0  = (state_reg == ST_OWN0);
  assign own1  = (state_reg == ST_OWN1);
  assign gnt_o = {own1, own0};
  assign term  = s_ack_i | s_err_i | s_rty_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= ST_IDLE;
      last_owner_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      last_owner_reg <= last_owner_next;
    end
  end

  // Ownership is released only when the owner drops cyc; the release edge
  // re-arbitrates immediately so a waiting master gets a direct handover.
  always_comb begin
    state_next      = state_reg;
    last_owner_next = last_owner_reg;
    case (state_reg)
      ST_IDLE: state_next = arbitrate(m0_cyc_i, m1_cyc_i, last_owner_reg);
      ST_OWN0: begin
        if (!m0_cyc_i) begin
          last_owner_next = 1'b0;
          state_next      = arbitrate(m0_cyc_i, m1_cyc_i, 1'b0);
        end
      end
      ST_OWN1: begin
        if (!m1_cyc_i) begin
          last_owner_next = 1'b1;
          state_next      = arbitrate(m0_cyc_i, m1_cyc_i, 1'b1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    s_addr_o = '0;
    s_data_o = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    if (own0) begin
      s_addr_o = m0_addr_i;
      s_data_o = m0_data_i;
      s_sel_o  = m0_sel_i;
      s_we_o   = m0_we_i;
      s_cyc_o  = m0_cyc_i;
      s_stb_o  = m0_cyc_i & m0_stb_i;
    end else if (own1) begin
      s_addr_o = m1_addr_i;
      s_data_o = m1_data_i;
      s_sel_o  = m1_sel_i;
      s_we_o   = m1_we_i;
      s_cyc_o  = m1_cyc_i;
      s_stb_o  = m1_cyc_i & m1_stb_i;
    end
  end

  // Terminations reach the owner only, and only while it still holds cyc.
  always_comb begin
    m0_ack_o = own0 & m0_cyc_i & s_ack_i;
    m0_err_o = own0 & m0_cyc_i & (s_err_i | expire);
    m0_rty_o = own0 & m0_cyc_i & s_rty_i;
    m1_ack_o = own1 & m1_cyc_i & s_ack_i;
    m1_err_o = own1 & m1_cyc_i & (s_err_i | expire);
    m1_rty_o = own1 & m1_cyc_i & s_rty_i;
  end

  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wdog
      wb_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_WIDTH      (TO_WIDTH)
      ) u_timeout_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .stb   (s_stb_o),
        .term  (term),
        .expire(expire)
      );
    end else begin : g_no_wdog
      assign expire = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_wb_arbiter_2m_1s.sv
// Directed bench for the two-master Wishbone arbiter with a 4-cycle watchdog.
module tb_wb_arbiter_2m_1s;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] m0_addr_i, m0_data_i, m0_data_o;
  logic [31:0] m1_addr_i, m1_data_i, m1_data_o;
  logic        m0_cyc_i, m0_stb_i, m0_we_i, m0_ack_o, m0_err_o, m0_rty_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i, m1_ack_o, m1_err_o, m1_rty_o;
  logic [3:0]  m0_sel_i, m1_sel_i, s_sel_o;
  logic [31:0] s_addr_o, s_data_o, s_data_i;
  logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i, s_rty_i;
  logic [1:0]  gnt_o;

  int total  = 0;
  int passed = 0;

  always #5 clk_i = ~clk_i;

  wb_arbiter_2m_1s #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4), .TO_WIDTH(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_data_o(m0_data_o),
    .m0_cyc_i(m0_cyc_i), .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_data_o(m1_data_o),
    .m1_cyc_i(m1_cyc_i), .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .gnt_o(gnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled 2 time units after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    m0_addr_i = '0; m0_data_i = '0; m0_cyc_i = 0; m0_sel_i = '0; m0_stb_i = 0; m0_we_i = 0;
    m1_addr_i = '0; m1_data_i = '0; m1_cyc_i = 0; m1_sel_i = '0; m1_stb_i = 0; m1_we_i = 0;
    s_data_i = '0; s_ack_i = 0; s_err_i = 0; s_rty_i = 0;
    #3;
    chk("rst_gnt", 32'(gnt_o), 32'h0);
    chk("rst_s_cyc", 32'(s_cyc_o), 32'h0);
    step();
    rst_i = 1'b0;

    // Single write from m0
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_addr_i = 32'h10;
    m0_data_i = 32'hDEADBEEF; m0_sel_i = 4'hF;
    #1;
    chk("lat_gnt", 32'(gnt_o), 32'h0);
    chk("lat_s_stb", 32'(s_stb_o), 32'h0);
    step();
    chk("wr_gnt", 32'(gnt_o), 32'h1);
    chk("wr_addr", s_addr_o, 32'h10);
    chk("wr_data", s_data_o, 32'hDEADBEEF);
    chk("wr_we", 32'(s_we_o), 32'h1);
    chk("wr_sel", 32'(s_sel_o), 32'hF);
    s_ack_i = 1;
    #1;
    chk("wr_m0_ack", 32'(m0_ack_o), 32'h1);
    chk("wr_m1_ack", 32'(m1_ack_o), 32'h0);
    step();
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
    #1;
    chk("drop_s_cyc", 32'(s_cyc_o), 32'h0);
    step();
    chk("rel_gnt", 32'(gnt_o), 32'h0);

    // Tie after reset goes to m0, then direct handover to m1
    do_reset();
    m0_cyc_i = 1; m1_cyc_i = 1;
    step();
    chk("tie_gnt", 32'(gnt_o), 32'h1);
    m0_cyc_i = 0;
    step();
    chk("hand_gnt", 32'(gnt_o), 32'h2);
    chk("hand_s_cyc", 32'(s_cyc_o), 32'h1);

    // m1 keeps ownership over three strobes with gaps while m0 waits
    m0_cyc_i = 1; m1_addr_i = 32'h200;
    for (int i = 0; i < 3; i++) begin
      m1_stb_i = 1; s_ack_i = 1;
      #1;
      chk("blk_m1_ack", 32'(m1_ack_o), 32'h1);
      chk("blk_m0_ack", 32'(m0_ack_o), 32'h0);
      step();
      m1_stb_i = 0; s_ack_i = 0;
      step();
      chk("blk_gnt", 32'(gnt_o), 32'h2);
    end
    m1_cyc_i = 0;
    step();
    chk("blk_rel_gnt", 32'(gnt_o), 32'h1);

    // Watchdog: no slave response, err in the 4th strobe cycle only
    m0_stb_i = 1; m0_we_i = 0; s_data_i = 32'h12345678;
    #1;
    chk("fanout_m1", m1_data_o, 32'h12345678);
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) step();
      chk("to_m0_err", 32'(m0_err_o), (c == 4) ? 32'h1 : 32'h0);
      chk("to_m1_err", 32'(m1_err_o), 32'h0);
    end

    // Ack lands in the cycle the watchdog would fire
    step();
    step();
    step();
    s_ack_i = 1;
    #1;
    chk("race_ack", 32'(m0_ack_o), 32'h1);
    chk("race_err", 32'(m0_err_o), 32'h0);
    step();
    s_ack_i = 0;
    #1;
    chk("race_after", 32'(m0_err_o), 32'h0);

    // Asynchronous reset mid-access, then tie goes to m0
    m1_cyc_i = 1;
    #2;
    rst_i = 1;
    #1;
    chk("arst_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("arst_s_stb", 32'(s_stb_o), 32'h0);
    chk("arst_gnt", 32'(gnt_o), 32'h0);
    step();
    rst_i = 0;
    step();
    chk("arst_tie", 32'(gnt_o), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_2m_1s.md
Name: wb_arbiter_2m_1s

Overview:
- Wishbone classic arbiter that shares one slave port between two masters, m0 and m1.
- Typical use: a CPU data port and a DMA engine sharing one wb_interconnect slave segment.
- Grant is round-robin, registered, and held for the whole bus cycle (while the owner holds cyc).
- An optional watchdog terminates a stalled slave access with err.

Parameters:
ADDR_WIDTH, 32, address width on all ports
DATA_WIDTH, 32, data width on all ports
TIMEOUT_CYCLES, 255, cycles of stb without ack/err/rty before a forced err; 0 disables the watchdog
TO_WIDTH, 8, watchdog counter width; must be large enough to hold TIMEOUT_CYCLES

Ports:
clk_i  input  1  system clock, all state on the rising edge
rst_i  input  1  reset, asynchronous, active-high
m0_addr_i / m1_addr_i  input  ADDR_WIDTH  master address
m0_data_i / m1_data_i  input  DATA_WIDTH  master write data
m0_data_o / m1_data_o  output  DATA_WIDTH  read data (s_data_i fanned out to both)
m0_cyc_i / m1_cyc_i  input  1  bus request / cycle valid
m0_sel_i / m1_sel_i  input  4  byte selects
m0_stb_i / m1_stb_i  input  1  strobe
m0_we_i / m1_we_i  input  1  write enable
m0_ack_o / m1_ack_o  output  1  ack, owner only
m0_err_o / m1_err_o  output  1  err, owner only (includes timeout err)
m0_rty_o / m1_rty_o  output  1  rty, owner only
s_addr_o  output  ADDR_WIDTH  slave address
s_data_o  output  DATA_WIDTH  slave write data
s_data_i  input  DATA_WIDTH  slave read data
s_cyc_o, s_stb_o, s_we_o  output  1  slave controls
s_sel_o  output  4  slave byte selects
s_ack_i, s_err_i, s_rty_i  input  1  slave terminations
gnt_o  output  2  one-hot current owner, debug/observability

Behaviour:
- FSM states: IDLE, OWN0, OWN1. State register and last_owner bit are the only arbitration state. gnt_o = {state==OWN1, state==OWN0}.
- Reset (asynchronous, takes effect immediately, including mid-cycle):
  - state=IDLE, last_owner=1, so m0 wins the first tie.
  - Timeout counter=0.
  - All s_* controls and all m*_ack/err/rty outputs are 0 while in IDLE.
- IDLE:
  - Only m0_cyc_i high -> OWN0. Only m1_cyc_i high -> OWN1.
  - Both high -> the master != last_owner.
  - Neither high -> stay in IDLE.
  - Grant latency is one clock: a slave sees cyc/stb at the earliest in the cycle after the request first appears.
- OWNx:
  - Muxing: s_addr/data/sel/we come from mx. s_cyc_o = mx_cyc_i, s_stb_o = mx_cyc_i & mx_stb_i.
  - Termination routing: s_ack/err/rty go to mx only; the other master's terminations are 0.
  - Ownership is held while mx_cyc_i=1, regardless of stb gaps (block/RMW cycles stay atomic).
  - On the edge where mx_cyc_i=0: last_owner<=x, then arbitrate exactly as in IDLE using the same-cycle cyc inputs. Direct OWN0->OWN1 handover is allowed with no idle cycle.
  - s_cyc_o is combinational from the owner's cyc, so it drops the same cycle the owner drops cyc.
- m0_data_o = m1_data_o = s_data_i; a master qualifies read data with its own ack.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter clears when s_stb_o=0 or any slave termination arrives; otherwise it increments.
  - When counter==TIMEOUT_CYCLES-1 and no termination is present, the owner's err_o is forced to 1 for that cycle and the counter clears.
  - The slave's late ack for that access is not suppressed; the master has already moved on.
  - With TIMEOUT_CYCLES=0 the counter logic is absent.
- Simultaneous events:
  - Slave termination and timeout in the same cycle: the slave termination is passed through and the counter clears; no extra err.
  - Owner drops cyc while a slave ack is in flight: the ack is discarded and ownership is released.
- Width: counter is TO_WIDTH bits, saturating, and never wraps.

Decomposition:
- wb_pkg holds the constants ST_IDLE/ST_OWN0/ST_OWN1 (2-bit encoding) and the WB_SEL_WIDTH=4 constant.
- One sub-module, wb_timeout_cnt (stb, term, expire), instantiated under a generate on TIMEOUT_CYCLES>0.
- Muxing and FSM stay in the top module.

Test Plan:
- Reset then m0_cyc/stb write, addr=0x10, data=0xDEADBEEF -> gnt_o=01 one clock later; s_addr_o=0x10, s_data_o=0xDEADBEEF, s_we_o=1; s_ack_i pulse reaches m0_ack_o only.
- m0 and m1 cyc asserted together from IDLE after reset -> m0 granted. Repeat after m0 releases with both still requesting -> direct handover to m1 (gnt_o 01->10, no IDLE cycle).
- m1 owns and holds cyc across 3 strobes with stb gaps while m0 requests -> gnt_o stays 10 until m1_cyc_i drops; m0 gets grant the next edge.
- TIMEOUT_CYCLES=4: m0 stb with no slave response -> m0_err_o=1 exactly in the 4th cycle of stb; m1 outputs stay 0.
- Slave ack arrives in the same cycle as the timeout would fire -> m0_ack_o=1, m0_err_o=0.
- rst_i asserted asynchronously mid-access (between clock edges) -> s_cyc_o, s_stb_o, gnt_o go 0 immediately. After release with both requesting, m0 wins.
